// File: rtl/rr_mux_demux_link_pkg.sv
// ============================================================================
// Module : rr_mux_demux_link_pkg
// Brief  : Shared mode encoding and index helper for the round-robin link.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rr_mux_demux_link_pkg;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } link_mode_e;

  // Advance idx by step (1..n) with wrap; idx < n is assumed.
  function automatic int wrap_inc(input int idx, input int step, input int n);
    int s;
    s = idx + step;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_mux_demux_link_if.sv
// ============================================================================
// Module : rr_mux_demux_link_if
// Brief  : Producer-side handshake, shared bus and demux outputs of the link.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rr_mux_demux_link_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     bus_data;
  logic [SELW-1:0]      bus_ch;
  logic                 bus_valid;
  logic [NCH*WIDTH-1:0] out_data;
  logic [NCH-1:0]       out_valid;

  modport master (
    output in_data, in_valid, mode, sel,
    input  in_ready, bus_data, bus_ch, bus_valid, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel,
    output in_ready, bus_data, bus_ch, bus_valid, out_data, out_valid
  );

endinterface

`default_nettype wire

// File: rtl/rr_mux_demux_link_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin / fixed-select grant, one-hot output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import rr_mux_demux_link_pkg::*;
#(
  parameter  int NCH  = 4,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  int w_c;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    w_c     = 0;
    if (mode == MODE_FIXED) begin
      for (int c = 0; c < NCH; c++) begin
        if (sel == SELW'(c) && req[c]) begin
          gnt      = '0;
          gnt[c]   = 1'b1;
          gnt_idx  = SELW'(c);
          gnt_any  = 1'b1;
        end
      end
    end else begin
      // Walk from the farthest candidate inward so the nearest request wins.
      for (int k = NCH; k >= 1; k--) begin
        w_c = wrap_inc(int'(ptr), k, NCH);
        if (req[w_c]) begin
          gnt       = '0;
          gnt[w_c]  = 1'b1;
          gnt_idx   = SELW'(w_c);
          gnt_any   = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux_demux_link.sv
// ============================================================================
// Module : rr_mux_demux_link
// Brief  : NCH channels share one registered link word per cycle; demux stage
//          returns each word to its channel holding register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_mux_demux_link
  import rr_mux_demux_link_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  rr_mux_demux_link_if.slave link
);

  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [SELW-1:0]      r_ptr;
  logic [WIDTH-1:0]     r_bus_data;
  logic [SELW-1:0]      r_bus_ch;
  logic                 r_bus_valid;
  logic [NCH*WIDTH-1:0] r_out_data;
  logic [NCH-1:0]       r_out_valid;

  logic [NCH-1:0]       w_gnt;
  logic [SELW-1:0]      w_gnt_idx;
  logic                 w_gnt_any;
  logic                 w_take;
  logic [WIDTH-1:0]     w_sel_data;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (link.in_valid),
    .ptr     (r_ptr),
    .mode    (link.mode),
    .sel     (link.sel),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_gnt_any)
  );

  // No transfer is offered while reset is held.
  assign w_take        = w_gnt_any & ~rst;
  assign link.in_ready = w_gnt & {NCH{~rst}};

  always_comb begin
    w_sel_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_gnt[c]) w_sel_data = link.in_data[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= SELW'(NCH - 1);
      r_bus_data  <= '0;
      r_bus_ch    <= '0;
      r_bus_valid <= 1'b0;
    end else begin
      r_bus_valid <= w_take;
      if (w_take) begin
        r_bus_data <= w_sel_data;
        r_bus_ch   <= w_gnt_idx;
        r_ptr      <= w_gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= '0;
    end else begin
      r_out_valid <= '0;
      for (int c = 0; c < NCH; c++) begin
        if (r_bus_valid && r_bus_ch == SELW'(c)) begin
          r_out_data[c*WIDTH +: WIDTH] <= r_bus_data;
          r_out_valid[c]               <= 1'b1;
        end
      end
    end
  end

  assign link.bus_data  = r_bus_data;
  assign link.bus_ch    = r_bus_ch;
  assign link.bus_valid = r_bus_valid;
  assign link.out_data  = r_out_data;
  assign link.out_valid = r_out_valid;

endmodule

`default_nettype wire
